// File: rtl/fpga_if_pkg.sv
// fpga_if_pkg
//   Shared definitions for the board-level debug front end (fpga_interface):
//   - pipeline stage encoding used by the stage-select switches
//   - active-low 7-segment patterns and the blank pattern
//   - number of decimal digits shown and a power-of-ten helper used to
//     build the constant dividers for digit extraction
package fpga_if_pkg;

  // Stage codes as they appear on SW[2:0]
  typedef enum logic [2:0] {
    STAGE_FETCH       = 3'd0,
    STAGE_FETCH_WAIT  = 3'd1,
    STAGE_DECODE      = 3'd2,
    STAGE_EXECUTE     = 3'd3,
    STAGE_MEMORY      = 3'd4,
    STAGE_MEMORY_WAIT = 3'd5,
    STAGE_WRITEBACK   = 3'd6,
    STAGE_NONE        = 3'd7
  } stage_e;

  localparam int NUM_DIGITS = 6;

  // Segment order is {g,f,e,d,c,b,a}, active low
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Digits 0..9; codes 10..15 never come out of a decimal split and show blank
  localparam logic [6:0] seg_lut [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000,
    7'b1111111, 7'b1111111, 7'b1111111,
    7'b1111111, 7'b1111111, 7'b1111111
  };

  // 10**n, only ever called with elaboration-time constants
  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) begin
      r = r * 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// seg7_decoder
//   Maps one 4-bit digit code to its active-low 7-segment pattern.
// Ports
//   digit  in  4   digit code (0..9 shown, 10..15 blank)
//   seg    out 7   segments {g,f,e,d,c,b,a}, active low
module seg7_decoder
  import fpga_if_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  assign seg = seg_lut[digit];

endmodule

// File: rtl/fpga_interface.sv
// fpga_interface
//   Debug front end for the ARM32 pipeline on a DE1-SoC style board. In
//   manual-clock mode six active-low 7-seg digits show one decimal value,
//   either the register picked by SW[7:4] or the PC of the stage picked by
//   SW[2:0]. Digits refill one per clock (HEX0 first) and keep cycling so a
//   changing value is refreshed continuously. LEDR shows the selected stage's
//   opcode, inverted.
// Configuration
//   FPGA_IF_STAGE_LED_EN  when defined, LEDR[9:7] show ~stage_select in
//                         manual mode; otherwise they stay off (1).
// Ports
//   clk                    in   1      system clock
//   rst_n                  in   1      synchronous reset, active HIGH
//   pc_<stage>_unit        in   PC_W   PC of each pipeline stage
//   opcode_<stage>_unit    in   OPC_W  opcode of each pipeline stage
//   selected_reg_value     in   VAL_W  value of register chosen by SW[7:4]
//   SW                     in   10     [9] manual, [8] reg mode, [7:4] reg sel,
//                                      [3] unused, [2:0] stage sel
//   HEX0..HEX5             out  7      active-low digits, HEX0 least significant
//   LEDR                   out  10     active-low LEDs
// The digit count comes from fpga_if_pkg::NUM_DIGITS; the HEX port list is
// fixed at six to match the board.
module fpga_interface
  import fpga_if_pkg::*;
#(
  parameter int PC_W  = 7,
  parameter int OPC_W = 7,
  parameter int VAL_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PC_W-1:0]  pc_fetch_unit,
  input  logic [PC_W-1:0]  pc_fetch_wait_unit,
  input  logic [PC_W-1:0]  pc_decode_unit,
  input  logic [PC_W-1:0]  pc_execute_unit,
  input  logic [PC_W-1:0]  pc_memory_unit,
  input  logic [PC_W-1:0]  pc_memory_wait_unit,
  input  logic [PC_W-1:0]  pc_writeback_unit,
  input  logic [OPC_W-1:0] opcode_fetch_unit,
  input  logic [OPC_W-1:0] opcode_fetch_wait_unit,
  input  logic [OPC_W-1:0] opcode_decode_unit,
  input  logic [OPC_W-1:0] opcode_execute_unit,
  input  logic [OPC_W-1:0] opcode_memory_unit,
  input  logic [OPC_W-1:0] opcode_memory_wait_unit,
  input  logic [OPC_W-1:0] opcode_writeback_unit,
  input  logic [VAL_W-1:0] selected_reg_value,
  input  logic [9:0]       SW,
  output logic [6:0]       HEX0,
  output logic [6:0]       HEX1,
  output logic [6:0]       HEX2,
  output logic [6:0]       HEX3,
  output logic [6:0]       HEX4,
  output logic [6:0]       HEX5,
  output logic [9:0]       LEDR
);

  localparam int V_W   = (VAL_W > PC_W) ? VAL_W : PC_W;
  localparam int CNT_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_DIGITS - 1);

  logic       manual_clk_mode;
  logic       show_reg_mode;
  logic [3:0] reg_select;
  logic [2:0] stage_select;
  logic       unused_sw;

  assign manual_clk_mode = SW[9];
  assign show_reg_mode   = SW[8];
  assign reg_select      = SW[7:4];
  assign stage_select    = SW[2:0];
  assign unused_sw       = SW[3];

  logic [7:0] sel;
  assign sel = {show_reg_mode, reg_select, stage_select};

  logic [6:0]       seg_q [NUM_DIGITS];
  logic [CNT_W-1:0] cnt;
  logic [7:0]       sel_q;
  logic             valid_q;
  logic             mismatch;

  // Any switch move (or a fresh reset) invalidates what is on the display
  assign mismatch = !valid_q || (sel_q != sel);

  logic [PC_W-1:0]  stage_pc;
  logic [OPC_W-1:0] stage_opc;

  // Pick PC and opcode of the selected stage; STAGE_NONE reads as zero
  always_comb begin
    stage_pc  = '0;
    stage_opc = '0;
    case (stage_e'(stage_select))
      STAGE_FETCH:       begin stage_pc = pc_fetch_unit;       stage_opc = opcode_fetch_unit;       end
      STAGE_FETCH_WAIT:  begin stage_pc = pc_fetch_wait_unit;  stage_opc = opcode_fetch_wait_unit;  end
      STAGE_DECODE:      begin stage_pc = pc_decode_unit;      stage_opc = opcode_decode_unit;      end
      STAGE_EXECUTE:     begin stage_pc = pc_execute_unit;     stage_opc = opcode_execute_unit;     end
      STAGE_MEMORY:      begin stage_pc = pc_memory_unit;      stage_opc = opcode_memory_unit;      end
      STAGE_MEMORY_WAIT: begin stage_pc = pc_memory_wait_unit; stage_opc = opcode_memory_wait_unit; end
      STAGE_WRITEBACK:   begin stage_pc = pc_writeback_unit;   stage_opc = opcode_writeback_unit;   end
      default:           begin stage_pc = '0;                  stage_opc = '0;                      end
    endcase
  end

  logic [V_W-1:0] value;

  always_comb begin
    value = show_reg_mode ? V_W'(selected_reg_value) : V_W'(stage_pc);
  end

  // Each decimal digit uses its own constant divider; values above
  // 999999 simply lose their upper digits
  logic [3:0] digit_val [NUM_DIGITS];

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    assign digit_val[k] = 4'((value / V_W'(pow10(k))) % V_W'(10));
  end

  // A restart always writes digit 0; otherwise the fill pointer chooses
  logic [CNT_W-1:0] digit_idx;
  logic [3:0]       cur_digit;
  logic [6:0]       cur_seg;

  always_comb begin
    digit_idx = mismatch ? '0 : cnt;
    cur_digit = digit_val[0];
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (digit_idx == CNT_W'(k)) begin
        cur_digit = digit_val[k];
      end
    end
  end

  seg7_decoder u_seg7_decoder (
    .digit (cur_digit),
    .seg   (cur_seg)
  );

  // Fill/refresh engine: restart on mismatch, else write one digit per edge
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        seg_q[k] <= SEG_BLANK;
      end
      cnt     <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
    end else if (mismatch) begin
      sel_q    <= sel;
      valid_q  <= 1'b1;
      seg_q[0] <= cur_seg;
      for (int k = 1; k < NUM_DIGITS; k++) begin
        seg_q[k] <= SEG_BLANK;
      end
      cnt <= CNT_W'(1);
    end else begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (cnt == CNT_W'(k)) begin
          seg_q[k] <= cur_seg;
        end
      end
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    end
  end

  // Blank instantly on a switch move so stale digits never mix with new ones
  logic show;
  assign show = manual_clk_mode && !mismatch;

  assign HEX0 = show ? seg_q[0] : SEG_BLANK;
  assign HEX1 = show ? seg_q[1] : SEG_BLANK;
  assign HEX2 = show ? seg_q[2] : SEG_BLANK;
  assign HEX3 = show ? seg_q[3] : SEG_BLANK;
  assign HEX4 = show ? seg_q[4] : SEG_BLANK;
  assign HEX5 = show ? seg_q[5] : SEG_BLANK;

  // LEDs are active low, so the opcode is inverted onto them
  always_comb begin
    LEDR = 10'h3FF;
    if (manual_clk_mode) begin
      LEDR[6:0] = ~7'(stage_opc);
`ifdef FPGA_IF_STAGE_LED_EN
      LEDR[9:7] = ~stage_select;
`else
      LEDR[9:7] = 3'b111;
`endif
    end
  end

endmodule

// File: tb/tb_fpga_interface.sv
// tb_fpga_interface
//   Self-checking bench for fpga_interface. Expected HEX/LEDR values are
//   pushed onto a scoreboard queue as stimulus is applied and popped and
//   compared once the DUT has had its edge (or settle time).
module tb_fpga_interface;

  logic        clk;
  logic        rst_n;
  logic [6:0]  pc_arr  [7];
  logic [6:0]  opc_arr [7];
  logic [19:0] selected_reg_value;
  logic [9:0]  SW;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic [9:0]  LEDR;

  int n_compared;
  int n_mismatched;

  localparam logic [6:0] TB_SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000,
    7'b1111111, 7'b1111111, 7'b1111111,
    7'b1111111, 7'b1111111, 7'b1111111
  };
  localparam int B = 15;
  localparam logic [41:0] ALL_BLANK = {6{7'b1111111}};

  typedef struct {
    string       tag;
    logic [41:0] hex;
    logic [9:0]  ledr;
  } exp_t;

  exp_t exp_q [$];

  fpga_interface dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .pc_fetch_unit           (pc_arr[0]),
    .pc_fetch_wait_unit      (pc_arr[1]),
    .pc_decode_unit          (pc_arr[2]),
    .pc_execute_unit         (pc_arr[3]),
    .pc_memory_unit          (pc_arr[4]),
    .pc_memory_wait_unit     (pc_arr[5]),
    .pc_writeback_unit       (pc_arr[6]),
    .opcode_fetch_unit       (opc_arr[0]),
    .opcode_fetch_wait_unit  (opc_arr[1]),
    .opcode_decode_unit      (opc_arr[2]),
    .opcode_execute_unit     (opc_arr[3]),
    .opcode_memory_unit      (opc_arr[4]),
    .opcode_memory_wait_unit (opc_arr[5]),
    .opcode_writeback_unit   (opc_arr[6]),
    .selected_reg_value      (selected_reg_value),
    .SW                      (SW),
    .HEX0                    (HEX0),
    .HEX1                    (HEX1),
    .HEX2                    (HEX2),
    .HEX3                    (HEX3),
    .HEX4                    (HEX4),
    .HEX5                    (HEX5),
    .LEDR                    (LEDR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Six digits given explicitly, HEX5 first; B means blank
  function automatic logic [41:0] hv(input int d5, input int d4, input int d3,
                                     input int d2, input int d1, input int d0);
    return {TB_SEG[d5], TB_SEG[d4], TB_SEG[d3], TB_SEG[d2], TB_SEG[d1], TB_SEG[d0]};
  endfunction

  // Display after k edges of a fill of value v: low k digits shown, rest blank
  function automatic logic [41:0] fill_vec(input int v, input int k);
    logic [41:0] r;
    int p;
    p = 1;
    for (int j = 0; j < 6; j++) begin
      r[j*7 +: 7] = (j < k) ? TB_SEG[(v / p) % 10] : TB_SEG[B];
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [9:0] led_exp(input logic manual, input logic [2:0] stage);
    logic [9:0] r;
    r = 10'h3FF;
    if (manual) begin
      r[6:0] = (stage == 3'd7) ? 7'h7F : ~opc_arr[stage];
`ifdef FPGA_IF_STAGE_LED_EN
      r[9:7] = ~stage;
`endif
    end
    return r;
  endfunction

  function automatic logic [9:0] sw_of(input logic manual, input logic reg_mode,
                                       input logic [3:0] rsel, input logic [2:0] stage);
    return {manual, reg_mode, rsel, 1'b0, stage};
  endfunction

  task automatic checkOutput(input string tag, input logic [41:0] observed,
                             input logic [41:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, want %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic [9:0] sw,
                               input logic [19:0] val);
    rst_n              = rst;
    SW                 = sw;
    selected_reg_value = val;
  endtask

  task automatic push_exp(input string tag, input logic [41:0] hex,
                          input logic [9:0] ledr);
    exp_t e;
    e.tag  = tag;
    e.hex  = hex;
    e.ledr = ledr;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput({e.tag, "_hex"}, {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}, e.hex);
      checkOutput({e.tag, "_led"}, 42'(LEDR), 42'(e.ledr));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic settle();
    #1;
    drain();
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    pc_arr  = '{7'd0, 7'd11, 7'd22, 7'd33, 7'd88, 7'd55, 7'd66};
    opc_arr = '{7'd1, 7'd2, 7'd3, 7'd4, 7'd5, 7'd6, 7'd7};

    // Reset with manual mode off
    applyStimulus(1'b1, sw_of(1'b0, 1'b0, 4'd0, 3'd0), 20'd0);
    push_exp("reset", ALL_BLANK, 10'h3FF);
    tick();

    // Reg mode fill of 123456
    applyStimulus(1'b0, sw_of(1'b1, 1'b1, 4'd0, 3'd0), 20'd123456);
    push_exp("reg0_pre", ALL_BLANK, led_exp(1'b1, 3'd0));
    settle();
    for (int k = 1; k <= 6; k++) begin
      push_exp($sformatf("reg0_e%0d", k), fill_vec(123456, k), led_exp(1'b1, 3'd0));
      tick();
    end

    // Reg select 1, value 654321, then switch back with no edge
    applyStimulus(1'b0, sw_of(1'b1, 1'b1, 4'd1, 3'd0), 20'd654321);
    for (int k = 1; k <= 6; k++) begin
      push_exp($sformatf("reg1_e%0d", k), fill_vec(654321, k), led_exp(1'b1, 3'd0));
      tick();
    end
    applyStimulus(1'b0, sw_of(1'b1, 1'b1, 4'd0, 3'd0), 20'd654321);
    push_exp("reg_blank", ALL_BLANK, led_exp(1'b1, 3'd0));
    settle();

    // Value above 999999 keeps only its low six digits, then a running
    // value change refreshes one digit per edge
    applyStimulus(1'b0, sw_of(1'b1, 1'b1, 4'd2, 3'd0), 20'd1048575);
    for (int k = 1; k <= 6; k++) begin
      push_exp($sformatf("ovf_e%0d", k), fill_vec(1048575, k), led_exp(1'b1, 3'd0));
      tick();
    end
    applyStimulus(1'b0, sw_of(1'b1, 1'b1, 4'd2, 3'd0), 20'd999999);
    push_exp("run_e1", hv(0, 4, 8, 5, 7, 9), led_exp(1'b1, 3'd0));
    tick();
    push_exp("run_e2", hv(0, 4, 8, 5, 9, 9), led_exp(1'b1, 3'd0));
    tick();

    // Stage mode, stage 0 then stage 4
    applyStimulus(1'b0, sw_of(1'b1, 1'b0, 4'd0, 3'd0), 20'd999999);
    push_exp("stg0_pre", ALL_BLANK, led_exp(1'b1, 3'd0));
    settle();
    for (int k = 1; k <= 6; k++) begin
      push_exp($sformatf("stg0_e%0d", k), fill_vec(0, k), led_exp(1'b1, 3'd0));
      tick();
    end
    applyStimulus(1'b0, sw_of(1'b1, 1'b0, 4'd0, 3'd4), 20'd999999);
    push_exp("stg4_pre", ALL_BLANK, led_exp(1'b1, 3'd4));
    settle();
    for (int k = 1; k <= 6; k++) begin
      push_exp($sformatf("stg4_e%0d", k), fill_vec(88, k), led_exp(1'b1, 3'd4));
      tick();
    end

    // Sweep stages without clocking; returning to stage 4 restores its display
    for (int s = 0; s < 8; s++) begin
      applyStimulus(1'b0, sw_of(1'b1, 1'b0, 4'd0, 3'(s)), 20'd999999);
      push_exp($sformatf("sweep_s%0d", s), (s == 4) ? fill_vec(88, 6) : ALL_BLANK,
               led_exp(1'b1, 3'(s)));
      settle();
    end
    for (int k = 1; k <= 2; k++) begin
      push_exp($sformatf("stg7_e%0d", k), fill_vec(0, k), led_exp(1'b1, 3'd7));
      tick();
    end

    // Manual clock mode off: always blank
    applyStimulus(1'b0, sw_of(1'b0, 1'b0, 4'd0, 3'd0), 20'd999999);
    for (int k = 1; k <= 6; k++) begin
      push_exp($sformatf("auto_e%0d", k), ALL_BLANK, 10'h3FF);
      tick();
    end

    // Reset mid-fill, together with a select change
    applyStimulus(1'b0, sw_of(1'b1, 1'b1, 4'd0, 3'd0), 20'd123456);
    for (int k = 1; k <= 3; k++) begin
      push_exp($sformatf("mid_e%0d", k), fill_vec(123456, k), led_exp(1'b1, 3'd0));
      tick();
    end
    applyStimulus(1'b1, sw_of(1'b1, 1'b1, 4'd3, 3'd0), 20'd123456);
    push_exp("mid_rst", ALL_BLANK, led_exp(1'b1, 3'd0));
    tick();
    applyStimulus(1'b0, sw_of(1'b1, 1'b1, 4'd3, 3'd0), 20'd123456);
    push_exp("refill_pre", ALL_BLANK, led_exp(1'b1, 3'd0));
    settle();
    for (int k = 1; k <= 3; k++) begin
      push_exp($sformatf("refill_e%0d", k), fill_vec(123456, k), led_exp(1'b1, 3'd0));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
